clock_reset_sequencer: RTL and testbench
========================================

// Module: clock_reset_sequencer
// PURPOSE
//  Sits directly downstream of clock_unit: consumes its o_valid (clock-generator lock) and sequences
//  the domain resets for the ADC and DAC datapaths. Waits for lock to be stable, releases ADC reset,
//  then DAC reset, then flags ready. Lock loss at any point re-asserts every reset immediately.
//  Reports lock-acquisition timeout and counts relock events for debug.
// PARAMETERS
//  STABLE_CYCLES   256      cycles valid must stay high before first release (>=1)
//  GAP_CYCLES      16       cycles between ADC release and DAC release, and DAC release and ready (>=1)
//  TIMEOUT_CYCLES  1000000  cycles in WAIT_LOCK before o_timeout sets; 0 disables timeout
// PORTS
//  i_clock         in   1  system clock (same clock feeding clock_unit)
//  i_reset         in   1  asynchronous, active-low reset
//  i_valid         in   1  lock/valid from clock_unit; treated as asynchronous
//  o_adc_reset     out  1  active-high reset to ADC domain logic
//  o_dac_reset     out  1  active-high reset to DAC domain logic
//  o_ready         out  1  high when both domains released and lock stable
//  o_timeout       out  1  sticky: lock not acquired within TIMEOUT_CYCLES
//  o_relock_count  out  8  saturating count of lock-loss events after leaving WAIT_LOCK
//  o_state         out  3  current FSM state encoding (debug)
// BEHAVIOUR
//  - Reset (i_reset=0, async): state=WAIT_LOCK(0), o_adc_reset=1, o_dac_reset=1, o_ready=0,
//    o_timeout=0, o_relock_count=0, sync flops=0, all counters=0.
//  - i_valid passes a 2-flop synchronizer -> valid_s; rise/fall before edge k is seen by FSM at edge k+2.
//  - States: WAIT_LOCK=0, DEBOUNCE=1, REL_ADC=2, REL_DAC=3, RUN=4. Outputs are registered with
//    state and change on the same edge as the state transition.
//  - WAIT_LOCK: all resets 1, ready 0. valid_s=1 -> DEBOUNCE, cnt cleared.
//  - DEBOUNCE: cnt++ per cycle with valid_s=1; at cnt==STABLE_CYCLES-1 with valid_s=1 -> REL_ADC
//    (DEBOUNCE lasts exactly STABLE_CYCLES cycles). o_adc_reset falls on entry to REL_ADC.
//  - REL_ADC: GAP_CYCLES cycles -> REL_DAC; o_dac_reset falls on entry.
//  - REL_DAC: GAP_CYCLES cycles -> RUN; o_ready rises on entry. RUN held while valid_s=1.
//  - Lock loss: valid_s=0 in DEBOUNCE/REL_ADC/REL_DAC/RUN -> WAIT_LOCK on that edge; both resets 1,
//    ready 0 on that same edge; o_relock_count += 1, saturating at 255. Overrides any pending transition.
//  - Timeout: timer cleared on every entry to WAIT_LOCK, increments each WAIT_LOCK cycle, saturates;
//    o_timeout sets when timer reaches TIMEOUT_CYCLES-1 and stays 1 until i_reset. FSM still accepts
//    lock after timeout. TIMEOUT_CYCLES=0: o_timeout never sets.
//  - Ordering invariant: o_dac_reset=0 implies o_adc_reset=0; o_ready=1 implies both resets 0.
//  - Counter widths sized by $clog2 of respective parameter; no wrap in any counter.
//  - Reset asserted mid-sequence: immediate return to reset values regardless of state.
// TESTING
//  1 STABLE=4,GAP=2: i_valid rises before edge k -> adc_reset falls k+6, dac_reset k+8, ready k+10.
//  2 In RUN, drop i_valid before edge m -> both resets 1, ready 0 at edge m+2; relock_count=1.
//  3 i_valid glitch high 3 cycles during DEBOUNCE (STABLE=4) -> no release; back to WAIT_LOCK, count=1.
//  4 TIMEOUT=50, i_valid held 0 -> o_timeout=1 from cycle 50, sticky; later lock still reaches RUN.
//  5 Toggle lock 300 times through RUN -> o_relock_count saturates at 255.
//  6 Assert i_reset in REL_DAC -> all outputs return to reset values asynchronously, state=0.

Source files
------------

// File: rtl/clock_reset_sequencer.sv
// Clock/reset sequencer: debounces clock_unit lock, then releases
// ADC reset, DAC reset and ready in order; any lock loss re-asserts all.
// Ports:
//   i_clock, i_reset (async, active-low)
//   i_valid (async lock input)
//   o_adc_reset, o_dac_reset (active-high)
//   o_ready, o_timeout (sticky)
//   o_relock_count[7:0] (saturating), o_state[2:0] (debug)
module clock_reset_sequencer #(
  parameter int STABLE_CYCLES  = 256,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_valid,
  output logic       o_adc_reset,
  output logic       o_dac_reset,
  output logic       o_ready,
  output logic       o_timeout,
  output logic [7:0] o_relock_count,
  output logic [2:0] o_state
);

  localparam logic [2:0] S_WAIT    = 3'd0;
  localparam logic [2:0] S_DEB     = 3'd1;
  localparam logic [2:0] S_REL_ADC = 3'd2;
  localparam logic [2:0] S_REL_DAC = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;

  localparam int MAXC =
    (STABLE_CYCLES > GAP_CYCLES) ?
    STABLE_CYCLES : GAP_CYCLES;
  localparam int CW =
    (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ?
    $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CW-1:0] STB_LAST =
    CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST =
    TW'((TIMEOUT_CYCLES > 0) ?
        (TIMEOUT_CYCLES - 1) : 0);
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

  logic          r_sync1;
  logic          r_valid_s;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_timer;
  logic          r_adc_reset;
  logic          r_dac_reset;
  logic          r_ready;
  logic          r_timeout;
  logic [7:0]    r_relock;

  logic [2:0]    w_next;
  logic          w_loss;
  logic [CW-1:0] w_last;
  logic          w_cnt_done;

  assign w_last =
    (r_state == S_DEB) ? STB_LAST : GAP_LAST;
  assign w_cnt_done = (r_cnt == w_last);

  always_comb begin
    w_next = r_state;
    w_loss = 1'b0;
    unique case (r_state)
      S_WAIT: begin
        if (r_valid_s) w_next = S_DEB;
      end
      S_DEB: begin
        if (!r_valid_s) w_loss = 1'b1;
        else if (w_cnt_done) w_next = S_REL_ADC;
      end
      S_REL_ADC: begin
        if (!r_valid_s) w_loss = 1'b1;
        else if (w_cnt_done) w_next = S_REL_DAC;
      end
      S_REL_DAC: begin
        if (!r_valid_s) w_loss = 1'b1;
        else if (w_cnt_done) w_next = S_RUN;
      end
      S_RUN: begin
        if (!r_valid_s) w_loss = 1'b1;
      end
      default: w_next = S_WAIT;
    endcase
    // lock loss wins over any pending step
    if (w_loss) w_next = S_WAIT;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1   <= 1'b0;
      r_valid_s <= 1'b0;
    end else begin
      r_sync1   <= i_valid;
      r_valid_s <= r_sync1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_WAIT;
      r_cnt       <= '0;
      r_adc_reset <= 1'b1;
      r_dac_reset <= 1'b1;
      r_ready     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state != S_WAIT &&
               r_state != S_RUN &&
               !w_cnt_done)
        r_cnt <= r_cnt + CW'(1);
      // outputs follow the state being entered
      r_adc_reset <= !(w_next == S_REL_ADC ||
                       w_next == S_REL_DAC ||
                       w_next == S_RUN);
      r_dac_reset <= !(w_next == S_REL_DAC ||
                       w_next == S_RUN);
      r_ready     <= (w_next == S_RUN);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_timer   <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_next == S_WAIT && r_state != S_WAIT)
        r_timer <= '0;
      else if (r_state == S_WAIT &&
               r_timer != TMO_LAST)
        r_timer <= r_timer + TW'(1);
      if (TMO_EN && r_state == S_WAIT &&
          r_timer == TMO_LAST)
        r_timeout <= 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)
      r_relock <= 8'd0;
    else if (w_loss && r_relock != 8'd255)
      r_relock <= r_relock + 8'd1;
  end

  assign o_adc_reset    = r_adc_reset;
  assign o_dac_reset    = r_dac_reset;
  assign o_ready        = r_ready;
  assign o_timeout      = r_timeout;
  assign o_relock_count = r_relock;
  assign o_state        = r_state;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Bench for clock_reset_sequencer with
// STABLE=4, GAP=2, TIMEOUT=50.
module tb_clock_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic       adc_rst;
  logic       dac_rst;
  logic       rdy;
  logic       tmo;
  logic [7:0] rc;
  logic [2:0] st;

  int checks = 0;
  int errors = 0;

  clock_reset_sequencer #(
    .STABLE_CYCLES (4),
    .GAP_CYCLES    (2),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_valid       (valid),
    .o_adc_reset   (adc_rst),
    .o_dac_reset   (dac_rst),
    .o_ready       (rdy),
    .o_timeout     (tmo),
    .o_relock_count(rc),
    .o_state       (st)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] st;
    logic       adc;
    logic       dac;
    logic       rdy;
    logic       tmo;
    logic [7:0] rc;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm,
                         input vec_t e);
    chk({nm, ".st"},  32'(st),      32'(e.st));
    chk({nm, ".adc"}, 32'(adc_rst), 32'(e.adc));
    chk({nm, ".dac"}, 32'(dac_rst), 32'(e.dac));
    chk({nm, ".rdy"}, 32'(rdy),     32'(e.rdy));
    chk({nm, ".tmo"}, 32'(tmo),     32'(e.tmo));
    chk({nm, ".rc"},  32'(rc),      32'(e.rc));
  endtask

  function automatic vec_t mk(
    logic v, logic [2:0] s, logic a, logic d,
    logic r, logic t, logic [7:0] c);
    vec_t x;
    x.v = v; x.st = s; x.adc = a; x.dac = d;
    x.rdy = r; x.tmo = t; x.rc = c;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid = 1'b0;
    rst_n = 1'b0;
    step();
    #3 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    bit   found;

    // ADC drops at k+6, DAC k+8, ready k+10
    tbl[0]  = mk(1, 0, 1, 1, 0, 0, 0);
    tbl[1]  = mk(1, 0, 1, 1, 0, 0, 0);
    tbl[2]  = mk(1, 1, 1, 1, 0, 0, 0);
    tbl[3]  = mk(1, 1, 1, 1, 0, 0, 0);
    tbl[4]  = mk(1, 1, 1, 1, 0, 0, 0);
    tbl[5]  = mk(1, 1, 1, 1, 0, 0, 0);
    tbl[6]  = mk(1, 2, 0, 1, 0, 0, 0);
    tbl[7]  = mk(1, 2, 0, 1, 0, 0, 0);
    tbl[8]  = mk(1, 3, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 3, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 4, 0, 0, 1, 0, 0);
    tbl[11] = mk(1, 4, 0, 0, 1, 0, 0);
    tbl[12] = mk(1, 4, 0, 0, 1, 0, 0);
    // lock drop seen two edges later
    tbl[13] = mk(0, 4, 0, 0, 1, 0, 0);
    tbl[14] = mk(0, 4, 0, 0, 1, 0, 0);
    tbl[15] = mk(0, 0, 1, 1, 0, 0, 1);
    tbl[16] = mk(0, 0, 1, 1, 0, 0, 1);
    // 3-cycle glitch during debounce
    tbl[17] = mk(1, 0, 1, 1, 0, 0, 1);
    tbl[18] = mk(1, 0, 1, 1, 0, 0, 1);
    tbl[19] = mk(1, 1, 1, 1, 0, 0, 1);
    tbl[20] = mk(0, 1, 1, 1, 0, 0, 1);
    tbl[21] = mk(0, 1, 1, 1, 0, 0, 1);
    tbl[22] = mk(0, 0, 1, 1, 0, 0, 2);
    tbl[23] = mk(0, 0, 1, 1, 0, 0, 2);

    rv = mk(0, 0, 1, 1, 0, 0, 0);

    #22;
    chk_all("reset", rv);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      valid = tbl[i].v;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i]);
    end

    // timeout with lock held low
    do_reset();
    for (int i = 1; i < 50; i++) step();
    chk("tmo_edge49", 32'(tmo), 32'd0);
    step();
    chk("tmo_edge50", 32'(tmo), 32'd1);
    for (int i = 0; i < 50; i++) step();
    chk("tmo_sticky", 32'(tmo), 32'd1);
    valid = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("tmo_run_st", 32'(st), 32'd4);
    chk("tmo_run_rdy", 32'(rdy), 32'd1);
    chk("tmo_run_tmo", 32'(tmo), 32'd1);
    chk("tmo_run_rc", 32'(rc), 32'd0);

    // relock saturation
    for (int i = 0; i < 300; i++) begin
      valid = 1'b0;
      for (int j = 0; j < 3; j++) step();
      if (i == 0)
        chk("drop_st", 32'(st), 32'd0);
      valid = 1'b1;
      for (int j = 0; j < 11; j++) step();
      if (i == 99)
        chk("rc_100", 32'(rc), 32'd100);
      if (i % 50 == 0)
        chk($sformatf("loop_rdy%0d", i),
            32'(rdy), 32'd1);
    end
    chk("rc_sat", 32'(rc), 32'd255);
    chk("rc_sat_st", 32'(st), 32'd4);

    // async reset while in REL_DAC
    do_reset();
    valid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (st == 3'd3) found = 1'b1;
    end
    chk("reach_rel_dac", 32'(st), 32'd3);
    chk("rel_dac_adc", 32'(adc_rst), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", rv);
    #10 rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
